// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-N counter with enable, up/down direction, range-checked
// synchronous load and registered carry/borrow/ld_err pulses for cascading.
module bcd_mod_counter #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned RST_VAL = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_l,
  input  logic [3:0] ld_h,
  output logic [3:0] cnt_l,
  output logic [3:0] cnt_h,
  output logic       carry,
  output logic       borrow,
  output logic       ld_err
);

  localparam int unsigned MAX_VAL = MODULUS - 1;
  localparam logic [3:0]  MAX_L   = 4'(MAX_VAL % 10);
  localparam logic [3:0]  MAX_H   = 4'(MAX_VAL / 10);
  localparam logic [3:0]  RST_L   = 4'(RST_VAL % 10);
  localparam logic [3:0]  RST_H   = 4'(RST_VAL / 10);
  localparam logic [7:0]  MOD8    = 8'(MODULUS);

  // Reject out-of-range parameterisations at elaboration.
  if (MODULUS < 2 || MODULUS > 100 || RST_VAL >= MODULUS) begin : g_bad_param
    $error("bcd_mod_counter: MODULUS must be 2..100 and RST_VAL < MODULUS");
  end

  logic [7:0] ld_val;
  logic       ld_ok;
  logic       at_max;
  logic       at_zero;
  logic [3:0] nxt_l;
  logic [3:0] nxt_h;
  logic       nxt_carry;
  logic       nxt_borrow;
  logic       nxt_err;

  // Next-count selection: load beats count beats hold.
  always_comb begin
    nxt_l      = cnt_l;
    nxt_h      = cnt_h;
    nxt_carry  = 1'b0;
    nxt_borrow = 1'b0;
    nxt_err    = 1'b0;

    ld_val  = (8'(ld_h) * 8'd10) + 8'(ld_l);
    ld_ok   = (ld_l <= 4'd9) && (ld_h <= 4'd9) && (ld_val < MOD8);
    at_max  = (cnt_h == MAX_H) && (cnt_l == MAX_L);
    at_zero = (cnt_h == 4'd0) && (cnt_l == 4'd0);

    if (ld) begin
      if (ld_ok) begin
        nxt_l = ld_l;
        nxt_h = ld_h;
      end else begin
        nxt_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        // Wrap on the exact terminal value so non-decade moduli stop short of x9.
        if (at_max) begin
          nxt_l     = 4'd0;
          nxt_h     = 4'd0;
          nxt_carry = 1'b1;
        end else if (cnt_l == 4'd9) begin
          nxt_l = 4'd0;
          nxt_h = cnt_h + 4'd1;
        end else begin
          nxt_l = cnt_l + 4'd1;
        end
      end else begin
        if (at_zero) begin
          nxt_l      = MAX_L;
          nxt_h      = MAX_H;
          nxt_borrow = 1'b1;
        end else if (cnt_l == 4'd0) begin
          nxt_l = 4'd9;
          nxt_h = cnt_h - 4'd1;
        end else begin
          nxt_l = cnt_l - 4'd1;
        end
      end
    end
  end

  // Count and pulse registers; pulses self-clear every cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_l  <= RST_L;
      cnt_h  <= RST_H;
      carry  <= 1'b0;
      borrow <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      cnt_l  <= nxt_l;
      cnt_h  <= nxt_h;
      carry  <= nxt_carry;
      borrow <= nxt_borrow;
      ld_err <= nxt_err;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: directed scenarios plus randomized traffic checked
// against an integer-arithmetic model of the counting rules.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // a: mod 60 rst 58, b: mod 24, d: mod 100, s/h: seconds->hours cascade
  logic       en_a = 0, up_a = 0, ld_a = 0;
  logic       en_b = 0, up_b = 0, ld_b = 0;
  logic       en_d = 0, up_d = 0, ld_d = 0;
  logic       en_s = 0, up_s = 0, ld_s = 0;
  logic       up_h = 0, ld_h = 0;
  logic [3:0] ll_a = 0, lh_a = 0, ll_b = 0, lh_b = 0, ll_d = 0, lh_d = 0;
  logic [3:0] ll_s = 0, lh_s = 0, ll_h = 0, lh_h = 0;
  logic [3:0] cl_a, ch_a, cl_b, ch_b, cl_d, ch_d, cl_s, ch_s, cl_h, ch_h;
  logic       cy_a, bw_a, er_a, cy_b, bw_b, er_b, cy_d, bw_d, er_d;
  logic       cy_s, bw_s, er_s, cy_h, bw_h, er_h;

  bcd_mod_counter #(.MODULUS(60), .RST_VAL(58)) u_a (
    .clk(clk), .clr(clr), .en(en_a), .up(up_a), .ld(ld_a), .ld_l(ll_a), .ld_h(lh_a),
    .cnt_l(cl_a), .cnt_h(ch_a), .carry(cy_a), .borrow(bw_a), .ld_err(er_a));
  bcd_mod_counter #(.MODULUS(24), .RST_VAL(0)) u_b (
    .clk(clk), .clr(clr), .en(en_b), .up(up_b), .ld(ld_b), .ld_l(ll_b), .ld_h(lh_b),
    .cnt_l(cl_b), .cnt_h(ch_b), .carry(cy_b), .borrow(bw_b), .ld_err(er_b));
  bcd_mod_counter #(.MODULUS(100), .RST_VAL(0)) u_d (
    .clk(clk), .clr(clr), .en(en_d), .up(up_d), .ld(ld_d), .ld_l(ll_d), .ld_h(lh_d),
    .cnt_l(cl_d), .cnt_h(ch_d), .carry(cy_d), .borrow(bw_d), .ld_err(er_d));
  bcd_mod_counter #(.MODULUS(60), .RST_VAL(0)) u_s (
    .clk(clk), .clr(clr), .en(en_s), .up(up_s), .ld(ld_s), .ld_l(ll_s), .ld_h(lh_s),
    .cnt_l(cl_s), .cnt_h(ch_s), .carry(cy_s), .borrow(bw_s), .ld_err(er_s));
  bcd_mod_counter #(.MODULUS(24), .RST_VAL(0)) u_h (
    .clk(clk), .clr(clr), .en(cy_s), .up(up_h), .ld(ld_h), .ld_l(ll_h), .ld_h(lh_h),
    .cnt_l(cl_h), .cnt_h(ch_h), .carry(cy_h), .borrow(bw_h), .ld_err(er_h));

  logic [10:0] oa, ob, od, os, oh;
  assign oa = {ch_a, cl_a, cy_a, bw_a, er_a};
  assign ob = {ch_b, cl_b, cy_b, bw_b, er_b};
  assign od = {ch_d, cl_d, cy_d, bw_d, er_d};
  assign os = {ch_s, cl_s, cy_s, bw_s, er_s};
  assign oh = {ch_h, cl_h, cy_h, bw_h, er_h};

  // Model: plain integer value per instance plus {carry,borrow,ld_err}.
  int va = 58, vb = 0, vd = 0, vs = 0, vh = 0;
  logic [2:0] pa = 0, pb = 0, pd = 0, ps = 0, ph = 0;

  function automatic logic [2:0] ref_step(input int mod, input int v, input logic ld,
                                          input logic [3:0] ll, input logic [3:0] lh,
                                          input logic en, input logic up, output int nv);
    logic [2:0] p;
    p  = 3'b000;
    nv = v;
    if (ld) begin
      if (int'(ll) <= 9 && int'(lh) <= 9 && (10 * int'(lh) + int'(ll)) < mod)
        nv = 10 * int'(lh) + int'(ll);
      else
        p = 3'b001;
    end else if (en) begin
      if (up) begin
        if (v == mod - 1) p = 3'b100;
        nv = (v + 1) % mod;
      end else begin
        if (v == 0) p = 3'b010;
        nv = (v + mod - 1) % mod;
      end
    end
    return p;
  endfunction

  function automatic logic [10:0] expv(input int v, input logic [2:0] p);
    return {4'(v / 10), 4'(v % 10), p};
  endfunction

  // Advance one clock, step the model with the inputs present at the edge.
  task automatic tick();
    int   n;
    logic hen;
    @(posedge clk);
    hen = ps[2];
    pa = ref_step(60,  va, ld_a, ll_a, lh_a, en_a, up_a, n); va = n;
    pb = ref_step(24,  vb, ld_b, ll_b, lh_b, en_b, up_b, n); vb = n;
    pd = ref_step(100, vd, ld_d, ll_d, lh_d, en_d, up_d, n); vd = n;
    ps = ref_step(60,  vs, ld_s, ll_s, lh_s, en_s, up_s, n); vs = n;
    ph = ref_step(24,  vh, ld_h, ll_h, lh_h, hen,  up_h, n); vh = n;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (oa !== {4'd5, 4'd8, 3'b000}) begin
      n_fail++; $display("FAIL reset_init got=%h exp=%h", oa, {4'd5, 4'd8, 3'b000});
    end
    clr = 1'b0;
    en_a = 1'b1; up_a = 1'b1;
    tick(); tick();
    n_tests++;
    if (oa !== {4'd0, 4'd0, 3'b100}) begin
      n_fail++; $display("FAIL reset_precount got=%h exp=%h", oa, {4'd0, 4'd0, 3'b100});
    end
    #2 clr = 1'b1;
    #1;
    n_tests++;
    if (oa !== {4'd5, 4'd8, 3'b000}) begin
      n_fail++; $display("FAIL reset_async got=%h exp=%h", oa, {4'd5, 4'd8, 3'b000});
    end
    n_tests++;
    if ({ob, od} !== 22'd0) begin
      n_fail++; $display("FAIL reset_others got=%h exp=0", {ob, od});
    end
    va = 58; vb = 0; vd = 0; vs = 0; vh = 0;
    pa = 0; pb = 0; pd = 0; ps = 0; ph = 0;
    en_a = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_up_wrap();
    int ncy;
    logic [10:0] e [3];
    e[0] = {4'd5, 4'd9, 3'b000};
    e[1] = {4'd0, 4'd0, 3'b100};
    e[2] = {4'd0, 4'd1, 3'b000};
    en_a = 1'b1; up_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (oa !== e[i]) begin
        n_fail++; $display("FAIL up_wrap step%0d got=%h exp=%h", i, oa, e[i]);
      end
    end
    ncy = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (cy_a === 1'b1) ncy++;
      n_tests++;
      if (oa !== expv(va, pa)) begin
        n_fail++; $display("FAIL up_run cyc%0d got=%h exp=%h", i, oa, expv(va, pa));
      end
    end
    n_tests++;
    if (ncy !== 2) begin
      n_fail++; $display("FAIL carry_count got=%0d exp=2", ncy);
    end
    en_a = 1'b0;
  endtask

  task automatic test_down_wrap();
    logic [10:0] e [8];
    e[0] = {4'd0, 4'd1, 3'b000};
    e[1] = {4'd0, 4'd0, 3'b000};
    e[2] = {4'd2, 4'd3, 3'b010};
    e[3] = {4'd2, 4'd2, 3'b000};
    e[4] = {4'd2, 4'd3, 3'b000};
    e[5] = {4'd0, 4'd0, 3'b100};
    e[6] = {4'd2, 4'd0, 3'b000};
    e[7] = {4'd1, 4'd9, 3'b000};
    for (int i = 0; i < 8; i++) begin
      ld_b = 1'b0; en_b = 1'b0; up_b = 1'b0;
      case (i)
        0: begin ld_b = 1'b1; lh_b = 4'd0; ll_b = 4'd1; end
        1, 2: en_b = 1'b1;
        3: begin ld_b = 1'b1; lh_b = 4'd2; ll_b = 4'd2; end
        4, 5: begin en_b = 1'b1; up_b = 1'b1; end
        6: begin ld_b = 1'b1; lh_b = 4'd1; ll_b = 4'd9; end
        default: en_b = 1'b1;
      endcase
      // Step 6 loads 19 then steps up to 20; step 7 counts back down to 19.
      if (i == 6) begin
        tick();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
      end
      tick();
      n_tests++;
      if (ob !== e[i]) begin
        n_fail++; $display("FAIL down_wrap step%0d got=%h exp=%h", i, ob, e[i]);
      end
    end
    ld_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic test_load();
    logic [10:0] e [6];
    e[0] = {4'd1, 4'd5, 3'b000};
    e[1] = {4'd1, 4'd5, 3'b001};
    e[2] = {4'd1, 4'd5, 3'b000};
    e[3] = {4'd1, 4'd5, 3'b001};
    e[4] = {4'd2, 4'd3, 3'b000};
    e[5] = {4'd0, 4'd7, 3'b000};
    for (int i = 0; i < 6; i++) begin
      ld_b = 1'b1; en_b = 1'b0; up_b = 1'b1;
      case (i)
        0: begin lh_b = 4'd1; ll_b = 4'd5; end
        1: begin lh_b = 4'd2; ll_b = 4'd4; end
        2: ld_b = 1'b0;
        3: begin lh_b = 4'd0; ll_b = 4'd10; end
        4: begin lh_b = 4'd2; ll_b = 4'd3; end
        default: begin lh_b = 4'd0; ll_b = 4'd7; en_b = 1'b1; end
      endcase
      tick();
      n_tests++;
      if (ob !== e[i]) begin
        n_fail++; $display("FAIL load step%0d got=%h exp=%h", i, ob, e[i]);
      end
    end
    ld_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic test_hold();
    ld_b = 1'b0; en_b = 1'b0; up_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (ob !== {4'd0, 4'd7, 3'b000}) begin
        n_fail++; $display("FAIL hold cyc%0d got=%h exp=%h", i, ob, {4'd0, 4'd7, 3'b000});
      end
    end
  endtask

  task automatic test_cascade();
    logic [21:0] e [4];
    e[0] = {4'd5, 4'd9, 3'b000, 4'd2, 4'd3, 3'b000};
    e[1] = {4'd0, 4'd0, 3'b100, 4'd2, 4'd3, 3'b000};
    e[2] = {4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 3'b100};
    e[3] = {4'd0, 4'd0, 3'b000, 4'd0, 4'd0, 3'b000};
    up_s = 1'b1; up_h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_s = (i == 0); ld_h = (i == 0); en_s = (i == 1);
      lh_s = 4'd5; ll_s = 4'd9; lh_h = 4'd2; ll_h = 4'd3;
      tick();
      n_tests++;
      if ({os, oh} !== e[i]) begin
        n_fail++; $display("FAIL cascade step%0d got=%h exp=%h", i, {os, oh}, e[i]);
      end
    end
    ld_s = 1'b0; ld_h = 1'b0; en_s = 1'b0;
  endtask

  task automatic test_mod100();
    logic [10:0] e [3];
    e[0] = {4'd9, 4'd9, 3'b000};
    e[1] = {4'd0, 4'd0, 3'b100};
    e[2] = {4'd9, 4'd9, 3'b010};
    for (int i = 0; i < 3; i++) begin
      ld_d = (i == 0); en_d = (i != 0); up_d = (i == 1);
      lh_d = 4'd9; ll_d = 4'd9;
      tick();
      n_tests++;
      if (od !== e[i]) begin
        n_fail++; $display("FAIL mod100 step%0d got=%h exp=%h", i, od, e[i]);
      end
    end
    ld_d = 1'b0; en_d = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ld_a = ($urandom_range(0, 7) == 0); en_a = 1'($urandom); up_a = 1'($urandom);
      ll_a = 4'($urandom_range(0, 11)); lh_a = 4'($urandom_range(0, 10));
      ld_b = ($urandom_range(0, 7) == 0); en_b = 1'($urandom); up_b = 1'($urandom);
      ll_b = 4'($urandom_range(0, 11)); lh_b = 4'($urandom_range(0, 3));
      ld_d = ($urandom_range(0, 7) == 0); en_d = 1'($urandom); up_d = 1'($urandom);
      ll_d = 4'($urandom_range(0, 15)); lh_d = 4'($urandom_range(0, 15));
      ld_s = ($urandom_range(0, 15) == 0); en_s = ($urandom_range(0, 3) != 0); up_s = 1'($urandom);
      ll_s = 4'($urandom_range(0, 9)); lh_s = 4'($urandom_range(0, 6));
      ld_h = ($urandom_range(0, 31) == 0); up_h = 1'($urandom);
      ll_h = 4'($urandom_range(0, 9)); lh_h = 4'($urandom_range(0, 2));
      tick();
      n_tests++;
      if ({oa, ob, od, os, oh} !== {expv(va, pa), expv(vb, pb), expv(vd, pd),
                                   expv(vs, ps), expv(vh, ph)}) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h %h %h %h %h exp=%h %h %h %h %h", i,
                 oa, ob, od, os, oh, expv(va, pa), expv(vb, pb), expv(vd, pd),
                 expv(vs, ps), expv(vh, ph));
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_cascade();
    test_mod100();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
